// File: rtl/dmem_access_unit.sv
// Load/store unit: forms rs1+imm, runs one request/grant/rvalid bus transaction per op,
// aligns and extends load data, and returns a one-cycle result pulse with error flags.
module dmem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int IMM_W   = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        in_funct3_i,
    input  logic              in_is_load_i,
    input  logic              in_is_store_i,
    input  logic [ADDR_W-1:0] in_base_i,
    input  logic [IMM_W-1:0]  in_imm_i,
    input  logic [31:0]       in_wdata_i,
    input  logic [4:0]        in_rd_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              out_valid_o,
    output logic [4:0]        out_rd_o,
    output logic [31:0]       out_rd_value_o,
    output logic              out_load_active_o,
    output logic              out_misaligned_o,
    output logic              out_bus_err_o
);
    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [2:0]        funct3_q;
    logic              is_load_q, mis_q;
    logic [1:0]        lane_q;
    logic [4:0]        rd_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic [4:0]        out_rd_q;
    logic [31:0]       out_val_q;
    logic              out_ld_q, out_mis_q, out_berr_q;

    logic [ADDR_W-1:0] addr_calc;
    logic [1:0]        lane, size;
    logic [3:0]        be_calc;
    logic [31:0]       wdata_calc;
    logic              mis_calc, accept;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_val;

    assign addr_calc = in_base_i + {{(ADDR_W-IMM_W){in_imm_i[IMM_W-1]}}, in_imm_i};
    assign lane      = addr_calc[1:0];
    assign size      = in_funct3_i[1:0];
    assign mis_calc  = ((size == 2'b01) && lane[0]) || (size[1] && (lane != 2'b00));
    assign accept    = in_valid_i && (state_q == S_IDLE) && (in_is_load_i || in_is_store_i);

    always_comb begin
        be_calc    = 4'hF;
        wdata_calc = in_wdata_i;
        case (size)
            2'b00: begin
                be_calc    = 4'b0001 << lane;
                wdata_calc = {4{in_wdata_i[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << {lane[1], 1'b0};
                wdata_calc = {2{in_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign byte_v = mem_rdata_i[{lane_q, 3'b000} +: 8];
    assign half_v = mem_rdata_i[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        load_val = mem_rdata_i;
        case (funct3_q[1:0])
            2'b00:   load_val = funct3_q[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   load_val = funct3_q[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: ;
        endcase
    end

    // Misaligned ops pass through REQ with the request gated, so the error pulse
    // lands at the same point a zero-wait bus access would.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_REQ;
                tmo_d   = '0;
            end
            S_REQ: begin
                if (mis_q) begin
                    state_d = S_ERR;
                end else if (mem_gnt_i) begin
                    tmo_d   = '0;
                    state_d = mem_rvalid_i ? S_RESP : S_WAIT;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i)            state_d = S_RESP;
                else if (tmo_q == TMO_LAST)  state_d = S_ERR;
                else                         tmo_d   = tmo_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            funct3_q    <= '0;
            is_load_q   <= 1'b0;
            mis_q       <= 1'b0;
            lane_q      <= '0;
            rd_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            out_rd_q    <= '0;
            out_val_q   <= '0;
            out_ld_q    <= 1'b0;
            out_mis_q   <= 1'b0;
            out_berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (accept) begin
                funct3_q    <= in_funct3_i;
                is_load_q   <= in_is_load_i;
                mis_q       <= mis_calc;
                lane_q      <= lane;
                rd_q        <= in_rd_i;
                mem_we_q    <= in_is_store_i;
                mem_addr_q  <= {addr_calc[ADDR_W-1:2], 2'b00};
                mem_be_q    <= be_calc;
                mem_wdata_q <= wdata_calc;
            end
            if (state_d == S_RESP && state_q != S_RESP) begin
                out_rd_q   <= rd_q;
                out_val_q  <= is_load_q ? load_val : 32'd0;
                out_ld_q   <= is_load_q;
                out_mis_q  <= 1'b0;
                out_berr_q <= 1'b0;
            end else if (state_d == S_ERR && state_q != S_ERR) begin
                out_rd_q   <= rd_q;
                out_val_q  <= 32'd0;
                out_ld_q   <= 1'b0;
                out_mis_q  <= mis_q;
                out_berr_q <= !mis_q;
            end
        end
    end

    assign in_ready_o        = (state_q == S_IDLE);
    assign mem_req_o         = (state_q == S_REQ) && !mis_q;
    assign mem_we_o          = mem_we_q;
    assign mem_addr_o        = mem_addr_q;
    assign mem_be_o          = mem_be_q;
    assign mem_wdata_o       = mem_wdata_q;
    assign out_valid_o       = (state_q == S_RESP) || (state_q == S_ERR);
    assign out_rd_o          = out_rd_q;
    assign out_rd_value_o    = out_val_q;
    assign out_load_active_o = out_ld_q;
    assign out_misaligned_o  = out_mis_q;
    assign out_bus_err_o     = out_berr_q;
endmodule
